// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// Build option: MUL_SAT_EN enables fractional-overflow saturation.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int N    = 8;
   localparam int CNT_W = $clog2(N) + 1;

   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A,
// then arithmetic right shift of {A,Q,q_-1}.
module booth_step
   import mul_pkg::*;
#(
   parameter int n = N
) (
   input  logic [n:0]   a_i,
   input  logic [n-1:0] q_i,
   input  logic         qm1_i,
   input  logic [n:0]   m_i,
   output logic [n:0]   a_o,
   output logic [n-1:0] q_o,
   output logic         qm1_o
);

   logic [n:0] sum;

   // Booth recoding on {Q[0], q_-1}, then shift sign-preserving
   always_comb begin
      sum = a_i;
      unique case ({q_i[0], qm1_i})
         2'b01:   sum = a_i + m_i;
         2'b10:   sum = a_i - m_i;
         default: sum = a_i;
      endcase
      a_o   = {sum[n], sum[n:1]};
      q_o   = {sum[0], q_i[n-1:1]};
      qm1_o = q_i[0];
   end

endmodule

// File: rtl/mul_unit.sv
// Sequential n x n signed Booth multiplier, integer or Q1.(n-1) output.
// Build option: MUL_SAT_EN saturates the -1 x -1 fractional case.
module mul_unit
   import mul_pkg::*;
#(
   parameter int n = N
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         frac,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] result
);

   localparam int CW = cnt_width(n);

   state_t         state_q, state_d;
   logic [n:0]     a_q, a_d;
   logic [n:0]     m_q, m_d;
   logic [n-1:0]   q_q, q_d;
   logic           qm1_q, qm1_d;
   logic           frac_q, frac_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [n-1:0]   res_q, res_d;

   logic [n:0]     nxt_a;
   logic [n-1:0]   nxt_q;
   logic           nxt_qm1;
   logic           last;
   logic           ovf;
   logic [n-1:0]   prod_lo;
   logic [n-1:0]   prod_fr;
   logic [n-1:0]   sel;

   booth_step #(.n(n)) u_step (
      .a_i   (a_q),
      .q_i   (q_q),
      .qm1_i (qm1_q),
      .m_i   (m_q),
      .a_o   (nxt_a),
      .q_o   (nxt_q),
      .qm1_o (nxt_qm1)
   );

   assign last = (state_q == RUN) && (cnt_q == CW'(n - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; start only matters in IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status outputs decoded from state
   always_comb begin
      busy   = (state_q != IDLE);
      done   = (state_q == DONE);
      result = res_q;
   end

   // Slice the final product straight off the last Booth step
   always_comb begin
      prod_lo = nxt_q;
      prod_fr = {nxt_a[n-2:0], nxt_q[n-1]};
`ifdef MUL_SAT_EN
      ovf = frac_q && (nxt_a[n-1] != nxt_a[n-2]);
`else
      ovf = 1'b0;
`endif
      if (ovf)         sel = {1'b0, {(n-1){1'b1}}};
      else if (frac_q) sel = prod_fr;
      else             sel = prod_lo;
   end

   // Datapath next-state: load on accept, step in RUN, capture on last
   always_comb begin
      a_d    = a_q;
      m_d    = m_q;
      q_d    = q_q;
      qm1_d  = qm1_q;
      frac_d = frac_q;
      cnt_d  = cnt_q;
      res_d  = res_q;
      if (state_q == IDLE && start) begin
         m_d    = {a[n-1], a};
         q_d    = b;
         a_d    = '0;
         qm1_d  = 1'b0;
         cnt_d  = '0;
         frac_d = frac;
      end else if (state_q == RUN) begin
         a_d   = nxt_a;
         q_d   = nxt_q;
         qm1_d = nxt_qm1;
         cnt_d = cnt_q + 1'b1;
         if (last) res_d = sel;
      end
   end

   // Datapath registers, cleared by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q    <= '0;
         m_q    <= '0;
         q_q    <= '0;
         qm1_q  <= 1'b0;
         frac_q <= 1'b0;
         cnt_q  <= '0;
         res_q  <= '0;
      end else begin
         a_q    <= a_d;
         m_q    <= m_d;
         q_q    <= q_d;
         qm1_q  <= qm1_d;
         frac_q <= frac_d;
         cnt_q  <= cnt_d;
         res_q  <= res_d;
      end
   end

endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: cycle-level reference model plus directed vectors.
// Honours MUL_SAT_EN for the fractional-overflow expectation.
module tb_mul_unit;

   localparam int NW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          frac;
   logic [NW-1:0] a;
   logic [NW-1:0] b;
   logic          busy;
   logic          done;
   logic [NW-1:0] result;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit armed = 1'b0;

   mul_unit #(.n(NW)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .frac   (frac),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   // Spec-level product: plain integer multiply, then pick the slice
   function automatic logic [NW-1:0] ref_calc(
      input logic [NW-1:0] x,
      input logic [NW-1:0] y,
      input logic          f
   );
      int xi, yi, p;
      xi = int'($signed(x));
      yi = int'($signed(y));
      p = xi * yi;
`ifdef MUL_SAT_EN
      if (f && p == 16384) return 8'h7F;
`endif
      if (f) p = p >>> (NW - 1);
      return NW'(p);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference timeline: phase 0 idle, 1..n run, n+1 done
   int            ph = 0;
   logic [NW-1:0] pend = '0;
   logic [NW-1:0] mres = '0;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         ph = 0;
         mres = '0;
      end else if (ph == 0) begin
         if (start) begin
            ph = 1;
            pend = ref_calc(a, b, frac);
         end
      end else if (ph == NW) begin
         ph = NW + 1;
         mres = pend;
      end else if (ph == NW + 1) begin
         ph = 0;
      end else begin
         ph = ph + 1;
      end
   end

   // Every-cycle comparison against the reference timeline
   always @(negedge clk) begin
      if (armed) begin
         chk("busy", int'(busy), int'(ph != 0));
         chk("done", int'(done), int'(ph == NW + 1));
         chk("result", int'(result), int'(mres));
      end
   end

   task automatic wait_done(output int n_neg);
      n_neg = 0;
      do begin
         @(negedge clk);
         n_neg++;
      end while (!done && n_neg < 30);
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic run_op(
      input string         nm,
      input logic [NW-1:0] x,
      input logic [NW-1:0] y,
      input logic          f,
      input logic [NW-1:0] exp
   );
      int n_neg;
      @(posedge clk); #1;
      start = 1'b1; a = x; b = y; frac = f;
      @(posedge clk); #1;
      start = 1'b0; a = 8'hA5; b = 8'h5A; frac = ~f;
      wait_done(n_neg);
      chk({nm, "_lat"}, n_neg, NW + 1);
      chk(nm, int'(result), int'(exp));
   endtask

   initial begin
      int n_neg;
      int dn;
      int t1;
      int t2;
      reset = 1'b1; start = 1'b0; frac = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      armed = 1'b1;
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_result", int'(result), 0);
      @(posedge clk); #1;
      reset = 1'b0;

      run_op("int_3x5",   8'd3,  8'd5,  1'b0, 8'h0F);
      run_op("int_m4x7",  8'hFC, 8'd7,  1'b0, 8'hE4);
      run_op("int_wrap",  8'h80, 8'h7F, 1'b0, 8'h80);
      run_op("frac_hh",   8'h40, 8'h40, 1'b1, 8'h20);
      run_op("frac_neg",  8'h40, 8'hC0, 1'b1, 8'hE0);
`ifdef MUL_SAT_EN
      run_op("frac_ovf",  8'h80, 8'h80, 1'b1, 8'h7F);
`else
      run_op("frac_ovf",  8'h80, 8'h80, 1'b1, 8'h80);
`endif
      run_op("int_ovf",   8'h80, 8'h80, 1'b0, 8'h00);

      // Start pulsed during RUN must be ignored
      @(posedge clk); #1;
      start = 1'b1; a = 8'd3; b = 8'd5; frac = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 start = 1'b1; a = 8'd9; b = 8'd9;
      @(posedge clk); #1;
      start = 1'b0;
      dn = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (done) begin
            dn++;
            chk("busy_rej_res", int'(result), 8'h0F);
         end
      end
      chk("busy_rej_pulses", dn, 1);

      // Start held high: back-to-back operations
      @(posedge clk); #1;
      start = 1'b1; a = 8'd2; b = 8'd3; frac = 1'b0;
      wait_done(n_neg);
      t1 = cyc;
      chk("b2b_res1", int'(result), 8'h06);
      @(negedge clk);
      wait_done(n_neg);
      t2 = cyc;
      start = 1'b0;
      chk("b2b_spacing", t2 - t1, NW + 2);
      repeat (3) @(posedge clk);

      // Reset mid-RUN at count 4
      @(posedge clk); #1;
      start = 1'b1; a = 8'd7; b = 8'd7; frac = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_result", int'(result), 0);
      dn = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("abort_no_done", dn, 0);

      run_op("post_abort", 8'hFF, 8'hFF, 1'b0, 8'h01);

      @(posedge clk);
      armed = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "timeout");
   end

endmodule
